// File: rtl/id_ex_reg.sv
// ---------------------------------------------------------------------------
// id_ex_reg -- ID/EX pipeline register of the 5-stage MIPS core.
//
// Captures the decode results and presents them to EX one cycle later.
// Handles stall bubbles, pipeline flush and branch delay-slot tagging, and
// hosts the load-use hazard detector feeding the stall controller.
//
// Ports:
//   clk, rst            rising-edge clock; synchronous active-high reset
//   stall[5:0]          stall vector: [2]=ID stalled, [3]=EX stalled
//   flush               synchronous pipeline flush
//   id_*                decode-stage results (op, operands, dest, inst, PC,
//                       taken-branch flag, register-read ports)
//   ex_*                registered copies presented to EX
//   ex_is_in_delayslot  EX instruction occupies a branch delay slot
//   id_is_in_delayslot  current ID instruction occupies a delay slot
//   load_use_stall      combinational stall request (load-use hazard)
// ---------------------------------------------------------------------------
module id_ex_reg #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [31:0]         id_reg1,
    input  logic [31:0]         id_reg2,
    input  logic [4:0]          id_wd,
    input  logic                id_wreg,
    input  logic [31:0]         id_return_addr,
    input  logic [31:0]         id_inst,
    input  logic [31:0]         id_pc,
    input  logic                id_branch_flag,
    input  logic                id_reg1_read,
    input  logic [4:0]          id_reg1_addr,
    input  logic                id_reg2_read,
    input  logic [4:0]          id_reg2_addr,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [31:0]         ex_reg1,
    output logic [31:0]         ex_reg2,
    output logic [4:0]          ex_wd,
    output logic                ex_wreg,
    output logic [31:0]         ex_return_addr,
    output logic [31:0]         ex_inst,
    output logic [31:0]         ex_pc,
    output logic                ex_is_in_delayslot,
    output logic                id_is_in_delayslot,
    output logic                load_use_stall
);

    // Load opcodes (inst[31:26]) that create a load-use hazard.
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    logic ex_is_load;
    logic next_in_delayslot;
    logic id_is_load;
    logic bubble;
    logic capture;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        id_is_load = 1'b0;
        case (id_inst[31:26])
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: id_is_load = 1'b1;
            default:                             id_is_load = 1'b0;
        endcase
    end

    // ID stalled while EX moves on: EX receives a NOP. A stall controller
    // never sends stall[2]=0 with stall[3]=1; that pattern simply captures.
    assign bubble  = stall[2] & ~stall[3];
    assign capture = ~stall[2];

    // NOTE: reset is sampled on the clock edge only (synchronous), and all
    // state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_aluop           <= '0;
            ex_alusel          <= '0;
            ex_reg1            <= '0;
            ex_reg2            <= '0;
            ex_wd              <= '0;
            ex_wreg            <= 1'b0;
            ex_return_addr     <= '0;
            ex_inst            <= '0;
            ex_pc              <= '0;
            ex_is_in_delayslot <= 1'b0;
            ex_is_load         <= 1'b0;
            next_in_delayslot  <= 1'b0;
        end else if (bubble) begin
            // The pending delay-slot tag stays with the stalled ID instruction.
            ex_aluop           <= '0;
            ex_alusel          <= '0;
            ex_reg1            <= '0;
            ex_reg2            <= '0;
            ex_wd              <= '0;
            ex_wreg            <= 1'b0;
            ex_return_addr     <= '0;
            ex_inst            <= '0;
            ex_pc              <= '0;
            ex_is_in_delayslot <= 1'b0;
            ex_is_load         <= 1'b0;
        end else if (capture) begin
            ex_aluop           <= id_aluop;
            ex_alusel          <= id_alusel;
            ex_reg1            <= id_reg1;
            ex_reg2            <= id_reg2;
            ex_wd              <= id_wd;
            ex_wreg            <= id_wreg;
            ex_return_addr     <= id_return_addr;
            ex_inst            <= id_inst;
            ex_pc              <= id_pc;
            ex_is_in_delayslot <= next_in_delayslot;
            ex_is_load         <= id_is_load;
            next_in_delayslot  <= id_branch_flag;
        end
        // Both stages stalled: everything holds.
    end

    assign id_is_in_delayslot = next_in_delayslot;

    // A load in EX whose destination is read by the instruction in ID needs
    // one bubble; r0 is never a real dependency.
    assign load_use_stall = ~rst & ex_is_load & ex_wreg & (ex_wd != 5'd0) &
                            ((id_reg1_read & (id_reg1_addr == ex_wd)) |
                             (id_reg2_read & (id_reg2_addr == ex_wd)));

endmodule

// File: tb/tb_id_ex_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_reg -- self-checking bench for id_ex_reg.
// Table of {inputs, expected load_use_stall before the edge, expected
// registered outputs after the edge}; expectations go through a scoreboard
// queue and are popped once the edge has produced the outputs.
// ---------------------------------------------------------------------------
module tb_id_ex_reg;

    localparam int ALUOP_W  = 8;
    localparam int ALUSEL_W = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          stall;
    logic                flush;
    logic [ALUOP_W-1:0]  id_aluop;
    logic [ALUSEL_W-1:0] id_alusel;
    logic [31:0]         id_reg1, id_reg2, id_return_addr, id_inst, id_pc;
    logic [4:0]          id_wd, id_reg1_addr, id_reg2_addr;
    logic                id_wreg, id_branch_flag, id_reg1_read, id_reg2_read;
    logic [ALUOP_W-1:0]  ex_aluop;
    logic [ALUSEL_W-1:0] ex_alusel;
    logic [31:0]         ex_reg1, ex_reg2, ex_return_addr, ex_inst, ex_pc;
    logic [4:0]          ex_wd;
    logic                ex_wreg, ex_is_in_delayslot, id_is_in_delayslot;
    logic                load_use_stall;

    always #5 clk = ~clk;

    id_ex_reg #(.ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1),
        .id_reg2(id_reg2), .id_wd(id_wd), .id_wreg(id_wreg),
        .id_return_addr(id_return_addr), .id_inst(id_inst), .id_pc(id_pc),
        .id_branch_flag(id_branch_flag), .id_reg1_read(id_reg1_read),
        .id_reg1_addr(id_reg1_addr), .id_reg2_read(id_reg2_read),
        .id_reg2_addr(id_reg2_addr), .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_return_addr(ex_return_addr), .ex_inst(ex_inst), .ex_pc(ex_pc),
        .ex_is_in_delayslot(ex_is_in_delayslot),
        .id_is_in_delayslot(id_is_in_delayslot),
        .load_use_stall(load_use_stall)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [7:0]  aluop;
        logic [31:0] reg1, reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] inst, pc;
        logic        br, r1rd;
        logic [4:0]  r1a;
        logic        r2rd;
        logic [4:0]  r2a;
    } in_t;

    typedef struct {
        logic [7:0]  aluop;
        logic [31:0] reg1, reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] inst, pc;
        logic        ex_ds, id_ds;
    } exp_t;

    typedef struct {
        in_t  i;
        logic lus;   // load_use_stall with these inputs, before the edge
        exp_t e;     // registered outputs after the edge
    } vec_t;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic in_t mk(input logic r, input logic [5:0] st, input logic fl,
                               input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] wd, input logic we, input logic [31:0] inst,
                               input logic [31:0] pc, input logic br, input logic r1rd,
                               input logic [4:0] r1a, input logic r2rd, input logic [4:0] r2a);
        in_t x;
        x.rst = r; x.stall = st; x.flush = fl; x.aluop = op; x.reg1 = a; x.reg2 = b;
        x.wd = wd; x.wreg = we; x.inst = inst; x.pc = pc; x.br = br;
        x.r1rd = r1rd; x.r1a = r1a; x.r2rd = r2rd; x.r2a = r2a;
        return x;
    endfunction

    // Expected outputs when the given inputs are captured.
    function automatic exp_t cap(input in_t x, input logic ex_ds, input logic id_ds);
        exp_t e;
        e.aluop = x.aluop; e.reg1 = x.reg1; e.reg2 = x.reg2; e.wd = x.wd;
        e.wreg = x.wreg; e.inst = x.inst; e.pc = x.pc; e.ex_ds = ex_ds; e.id_ds = id_ds;
        return e;
    endfunction

    // Expected outputs after a clear (bubble, flush or reset).
    function automatic exp_t zero(input logic id_ds);
        exp_t e;
        e.aluop = '0; e.reg1 = '0; e.reg2 = '0; e.wd = '0; e.wreg = 1'b0;
        e.inst = '0; e.pc = '0; e.ex_ds = 1'b0; e.id_ds = id_ds;
        return e;
    endfunction

    task automatic add(input in_t x, input logic lus, input exp_t e);
        vec_t v;
        v.i = x; v.lus = lus; v.e = e;
        vecs.push_back(v);
    endtask

    // alusel and return address are derived from the record so that a
    // cleared stage maps to zero on every field.
    task automatic drive(input in_t x);
        rst = x.rst; stall = x.stall; flush = x.flush;
        id_aluop = x.aluop; id_alusel = x.aluop[2:0];
        id_reg1 = x.reg1; id_reg2 = x.reg2; id_wd = x.wd; id_wreg = x.wreg;
        id_return_addr = {x.pc[30:0], 1'b0};
        id_inst = x.inst; id_pc = x.pc; id_branch_flag = x.br;
        id_reg1_read = x.r1rd; id_reg1_addr = x.r1a;
        id_reg2_read = x.r2rd; id_reg2_addr = x.r2a;
    endtask

    task automatic compare_out(input int k);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("v%0d scoreboard_empty", k), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("v%0d ex_aluop", k), 32'(ex_aluop), 32'(e.aluop));
            check($sformatf("v%0d ex_alusel", k), 32'(ex_alusel), 32'(e.aluop[2:0]));
            check($sformatf("v%0d ex_reg1", k), ex_reg1, e.reg1);
            check($sformatf("v%0d ex_reg2", k), ex_reg2, e.reg2);
            check($sformatf("v%0d ex_wd", k), 32'(ex_wd), 32'(e.wd));
            check($sformatf("v%0d ex_wreg", k), 32'(ex_wreg), 32'(e.wreg));
            check($sformatf("v%0d ex_return_addr", k), ex_return_addr, {e.pc[30:0], 1'b0});
            check($sformatf("v%0d ex_inst", k), ex_inst, e.inst);
            check($sformatf("v%0d ex_pc", k), ex_pc, e.pc);
            check($sformatf("v%0d ex_is_in_delayslot", k), 32'(ex_is_in_delayslot), 32'(e.ex_ds));
            check($sformatf("v%0d id_is_in_delayslot", k), 32'(id_is_in_delayslot), 32'(e.id_ds));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  x;
        exp_t c;
        logic [5:0] ops[10];
        logic       op_is_load[10];

        drive(mk(1, 6'b0, 0, 8'h0, 0, 0, 5'd0, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0));

        // Reset for two cycles, then a plain capture.
        x = mk(1, 6'b000000, 0, 8'h25, 32'h0000_1234, 32'hFFFF_0001, 5'd5, 1, 32'h00A0_2825, 32'h40, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, zero(0));
        add(x, 0, zero(0));
        x.rst = 0;
        add(x, 0, cap(x, 0, 0));
        // Bubble, then hold of the bubble.
        add(mk(0, 6'b000100, 0, 8'h11, 32'hAAAA_5555, 32'h1, 5'd7, 1, 32'h0, 32'h44, 0, 0, 5'd0, 0, 5'd0), 0, zero(0));
        add(mk(0, 6'b001100, 0, 8'h12, 32'h1111_2222, 32'h3, 5'd8, 1, 32'h0, 32'h48, 0, 0, 5'd0, 0, 5'd0), 0, zero(0));
        // Hold of non-zero contents; the branch flag on the held ID must not tag.
        x = mk(0, 6'b000000, 0, 8'h33, 32'h5555, 32'h6666, 5'd7, 1, 32'h3467_0001, 32'h4C, 0, 0, 5'd0, 0, 5'd0);
        c = cap(x, 0, 0);
        add(x, 0, c);
        add(mk(0, 6'b001100, 0, 8'h99, 32'hDEAD, 32'hBEEF, 5'd8, 0, 32'h8C22_0000, 32'h50, 1, 0, 5'd0, 0, 5'd0), 0, c);
        // Load-use via rs: LW r2, then a reader of r2 with the controller's stall.
        x = mk(0, 6'b000000, 0, 8'h23, 32'h1000, 32'h0, 5'd2, 1, 32'h8C22_0000, 32'h54, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b000111, 0, 8'h21, 32'h77, 32'h88, 5'd3, 1, 32'h0043_1821, 32'h58, 0, 1, 5'd2, 0, 5'd0);
        add(x, 1, zero(0));
        x.stall = 6'b000000;
        add(x, 0, cap(x, 0, 0));
        // No hazard: load to r0 read as r0.
        x = mk(0, 6'b000000, 0, 8'h23, 32'h2000, 32'h0, 5'd0, 1, 32'h8C20_0000, 32'h5C, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b000000, 0, 8'h00, 32'h0, 32'h0, 5'd4, 0, 32'h0, 32'h60, 0, 1, 5'd0, 1, 5'd0);
        add(x, 0, cap(x, 0, 0));
        // No hazard: load to r2, ID reads r3/r4.
        x = mk(0, 6'b000000, 0, 8'h23, 32'h3000, 32'h0, 5'd2, 1, 32'h8C22_0000, 32'h64, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b000000, 0, 8'h21, 32'h1, 32'h2, 5'd5, 1, 32'h0064_2821, 32'h68, 0, 1, 5'd3, 1, 5'd4);
        add(x, 0, cap(x, 0, 0));
        // No hazard: ORI to r2, ID reads r2.
        x = mk(0, 6'b000000, 0, 8'h25, 32'h4, 32'h5, 5'd2, 1, 32'h3422_0005, 32'h6C, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b000000, 0, 8'h21, 32'h6, 32'h7, 5'd6, 1, 32'h0, 32'h70, 0, 1, 5'd2, 1, 5'd2);
        add(x, 0, cap(x, 0, 0));
        // Load-use via rt: LHU r4, reader of r4 on the rt port only.
        x = mk(0, 6'b000000, 0, 8'h24, 32'h7000, 32'h0, 5'd4, 1, 32'h9444_0000, 32'h74, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        add(mk(0, 6'b000111, 0, 8'h21, 32'h9, 32'hA, 5'd5, 1, 32'h0, 32'h78, 0, 0, 5'd4, 1, 5'd4), 1, zero(0));
        // No hazard: load without write enable; illegal stall pattern captures.
        x = mk(0, 6'b000000, 0, 8'h23, 32'h0, 32'h0, 5'd6, 0, 32'h8006_0000, 32'h7C, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b001000, 0, 8'h21, 32'hB, 32'hC, 5'd7, 1, 32'h0, 32'h80, 0, 1, 5'd6, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        // No hazard: matching addresses but read enables low.
        x = mk(0, 6'b000000, 0, 8'h23, 32'hD, 32'h0, 5'd8, 1, 32'h8C08_0000, 32'h84, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        x = mk(0, 6'b000000, 0, 8'h21, 32'hE, 32'hF, 5'd9, 1, 32'h0, 32'h88, 0, 0, 5'd8, 0, 5'd8);
        add(x, 0, cap(x, 0, 0));
        // Delay slot: branch at 0x100, slot at 0x104, then untagged 0x108.
        x = mk(0, 6'b000000, 0, 8'h00, 32'h0, 32'h0, 5'd0, 0, 32'h1000_0004, 32'h100, 1, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 1));
        x = mk(0, 6'b000000, 0, 8'h25, 32'h1, 32'h2, 5'd3, 1, 32'h3423_0001, 32'h104, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 1, 0));
        x = mk(0, 6'b000000, 0, 8'h25, 32'h3, 32'h4, 5'd4, 1, 32'h3424_0002, 32'h108, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 0));
        // Delay slot across an ID stall bubble.
        x = mk(0, 6'b000000, 0, 8'h00, 32'h0, 32'h0, 5'd0, 0, 32'h1000_0008, 32'h200, 1, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 1));
        x = mk(0, 6'b000100, 0, 8'h25, 32'h5, 32'h6, 5'd5, 1, 32'h3425_0003, 32'h204, 0, 0, 5'd0, 0, 5'd0);
        add(x, 0, zero(1));
        x.stall = 6'b000000;
        add(x, 0, cap(x, 1, 0));
        // Flush with a pending tag and a live load-use hazard.
        x = mk(0, 6'b000000, 0, 8'h44, 32'h9, 32'h0, 5'd9, 1, 32'h8C29_0000, 32'h300, 1, 0, 5'd0, 0, 5'd0);
        add(x, 0, cap(x, 0, 1));
        x = mk(0, 6'b000100, 1, 8'h21, 32'h10, 32'h11, 5'd10, 1, 32'h0, 32'h304, 0, 1, 5'd9, 0, 5'd0);
        add(x, 1, zero(0));
        x.stall = 6'b000000; x.flush = 0;
        add(x, 0, cap(x, 0, 0));
        // Reset wins over a hold stall.
        add(mk(1, 6'b001100, 0, 8'h55, 32'h12, 32'h13, 5'd11, 1, 32'h0, 32'h308, 1, 0, 5'd0, 0, 5'd0), 0, zero(0));

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].i);
            #1;
            check($sformatf("v%0d load_use_stall", k), 32'(load_use_stall), 32'(vecs[k].lus));
            sb.push_back(vecs[k].e);
            @(posedge clk);
            #1;
            compare_out(k);
        end

        // Load opcode decode: capture an instruction writing r2, then check
        // the hazard flag against a reader of r2.
        ops = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
                6'b100010, 6'b101011, 6'b100110, 6'b001101, 6'b000000};
        op_is_load = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            drive(mk(0, 6'b0, 0, 8'h23, 32'h0, 32'h0, 5'd2, 1, {ops[n], 26'h0020000}, 32'h400, 0, 0, 5'd0, 0, 5'd0));
            @(negedge clk);
            drive(mk(0, 6'b0, 0, 8'h21, 32'h0, 32'h0, 5'd3, 1, 32'h0, 32'h404, 0, 1, 5'd2, 0, 5'd0));
            #1;
            check($sformatf("opcode %b load_use_stall", ops[n]), 32'(load_use_stall), 32'(op_is_load[n]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
